// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS -> RAVENS spike path.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS = 7;
  localparam int DVS_Y_ADDR_BITS = 7;
  localparam int DVS_WIDTH_PXLS  = 128;
  localparam int EVENT_BITS      = 31;
  localparam int RAVENS_PKT_BITS = 32;

  // Timestamp field is what is left after x, y and polarity.
  localparam int DVS_TS_BITS = EVENT_BITS - DVS_X_ADDR_BITS - DVS_Y_ADDR_BITS - 1;

  typedef enum logic [1:0] {SCHED_UNSYNC, SCHED_WAIT, SCHED_SEND} sched_state_t;

endpackage

// File: rtl/dvs_spike_scheduler_if.sv
// Event-in / spike-out handshake bundle of the spike scheduler.
interface dvs_spike_scheduler_if;
  import dvs_ravens_pkg::*;

  logic                       evt_valid;
  logic                       evt_ready;
  logic [EVENT_BITS-1:0]      evt_data;
  logic                       spk_valid;
  logic                       spk_ready;
  logic [RAVENS_PKT_BITS-1:0] spk_data;

  // Scheduler side: consumes events, produces spikes.
  modport slave  (input  evt_valid, evt_data, spk_ready,
                  output evt_ready, spk_valid, spk_data);
  // Environment side: produces events, consumes spikes.
  modport master (output evt_valid, evt_data, spk_ready,
                  input  evt_ready, spk_valid, spk_data);
endinterface

// File: rtl/dvs_event_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
module dvs_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);
  localparam logic [AW:0]   FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = ((r_wr ^ r_rd) == FULL_XOR);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + ONE;
      if (w_pop)  r_rd <= r_rd + ONE;
    end
  end

  // Storage needs no reset: empty pointers hide stale words.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/dvs_event_to_ravens_spike.sv
// Combinational DVS event -> RAVENS input spike packet mapping.
module dvs_event_to_ravens_spike
  import dvs_ravens_pkg::*;
(
  input  logic [EVENT_BITS-1:0]      i_evt,
  output logic [RAVENS_PKT_BITS-1:0] o_pkt
);
  logic [DVS_X_ADDR_BITS-1:0] w_x;
  logic [DVS_Y_ADDR_BITS-1:0] w_y;
  logic [7:0]                 w_idx;
  logic                       w_unused;

  assign w_x = i_evt[EVENT_BITS-1 -: DVS_X_ADDR_BITS];
  assign w_y = i_evt[EVENT_BITS-1-DVS_X_ADDR_BITS -: DVS_Y_ADDR_BITS];
  // Polarity and timestamp play no part in addressing.
  assign w_unused = ^i_evt[DVS_TS_BITS:0];

  // Pixel index modulo 256; core from the upper nibble, neuron from the lower.
  assign w_idx = 8'(w_x) + 8'(w_y) * 8'(DVS_WIDTH_PXLS);
  assign o_pkt = {3'b0, 16'b0, w_idx[7:4], w_idx[3:0], 5'b0};
endmodule

// File: rtl/dvs_spike_scheduler.sv
// Timestamp-paced release of buffered DVS events as RAVENS input spikes.
module dvs_spike_scheduler
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TICK_CYCLES = 100,
  parameter int MAX_LAG_US  = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  dvs_spike_scheduler_if.slave   bus,
  output logic [DVS_TS_BITS-1:0] now_us,
  output logic [15:0]            drop_cnt
);
  localparam int                            PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]                 PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic signed [DVS_TS_BITS-1:0] MAX_LAG  = DVS_TS_BITS'(MAX_LAG_US);

  sched_state_t               r_state, w_state_nxt;
  logic                       r_live;
  logic [PW-1:0]              r_pre;
  logic [DVS_TS_BITS-1:0]     r_now;
  logic [15:0]                r_drop;
  logic                       r_spk_valid;
  logic [RAVENS_PKT_BITS-1:0] r_spk_data;

  logic [EVENT_BITS-1:0]         w_head;
  logic                          w_full, w_empty, w_push, w_pop;
  logic [RAVENS_PKT_BITS-1:0]    w_pkt;
  logic signed [DVS_TS_BITS-1:0] w_lag;
  logic                          w_due, w_stale;
  logic                          w_sync, w_load, w_drop_inc, w_spk_clr;

  // r_live keeps evt_ready low while reset is asserted.
  assign bus.evt_ready = r_live & ~w_full & ~flush;
  assign w_push        = bus.evt_valid & bus.evt_ready;
  assign bus.spk_valid = r_spk_valid;
  assign bus.spk_data  = r_spk_data;
  assign now_us        = r_now;
  assign drop_cnt      = r_drop;

  dvs_event_fifo #(.WIDTH(EVENT_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (bus.evt_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  dvs_event_to_ravens_spike u_conv (
    .i_evt (w_head),
    .o_pkt (w_pkt)
  );

  // Modular difference read as signed handles timestamp wrap for free.
  assign w_lag   = $signed(r_now - w_head[DVS_TS_BITS-1:0]);
  assign w_due   = ~w_lag[DVS_TS_BITS-1];
  assign w_stale = (w_lag > MAX_LAG);

  // Out-of-reset marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // State register; flush forces a re-sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= SCHED_UNSYNC;
    else if (flush) r_state <= SCHED_UNSYNC;
    else            r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; stale drops win over release and ignore enable.
  always_comb begin
    w_state_nxt = r_state;
    w_sync      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_drop_inc  = 1'b0;
    w_spk_clr   = 1'b0;
    if (!flush) begin
      case (r_state)
        SCHED_UNSYNC: if (!w_empty) begin
          w_sync      = 1'b1;
          w_state_nxt = SCHED_WAIT;
        end
        SCHED_WAIT: if (!w_empty) begin
          if (w_stale) begin
            w_pop      = 1'b1;
            w_drop_inc = 1'b1;
          end else if (w_due && enable) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = SCHED_SEND;
          end
        end
        SCHED_SEND: if (bus.spk_ready) begin
          w_spk_clr   = 1'b1;
          w_state_nxt = SCHED_WAIT;
        end
        default: w_state_nxt = SCHED_UNSYNC;
      endcase
    end
  end

  // Prescaler and microsecond timebase; frozen until synced, now_us survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_now <= '0;
    end else if (flush) begin
      r_pre <= '0;
    end else if (w_sync) begin
      r_pre <= '0;
      r_now <= w_head[DVS_TS_BITS-1:0];
    end else if (r_state != SCHED_UNSYNC) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_now <= r_now + DVS_TS_BITS'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // Saturating stale-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_drop <= '0;
    else if (flush)                         r_drop <= '0;
    else if (w_drop_inc && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end

  // Spike output register, held stable until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spk_valid <= 1'b0;
      r_spk_data  <= '0;
    end else if (flush) begin
      r_spk_valid <= 1'b0;
      r_spk_data  <= '0;
    end else if (w_load) begin
      r_spk_valid <= 1'b1;
      r_spk_data  <= w_pkt;
    end else if (w_spk_clr) begin
      r_spk_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dvs_spike_scheduler.sv
// Bench for dvs_spike_scheduler: vector table, corner sequences, random vs model.
module tb_dvs_spike_scheduler;
  import dvs_ravens_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TICK   = 4;
  localparam int MAXLAG = 10;
  localparam int TSM    = 1 << DVS_TS_BITS;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   enable = 1'b1;
  logic                   flush = 1'b0;
  logic [DVS_TS_BITS-1:0] now_us;
  logic [15:0]            drop_cnt;

  dvs_spike_scheduler_if bus();

  dvs_spike_scheduler #(.FIFO_DEPTH(DEPTH), .TICK_CYCLES(TICK), .MAX_LAG_US(MAXLAG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .flush    (flush),
    .bus      (bus),
    .now_us   (now_us),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic                       en;
    logic                       ev_v;
    logic [EVENT_BITS-1:0]      ev;
    logic                       sr;
    logic                       e_rdy;
    logic                       e_sv;
    logic [RAVENS_PKT_BITS-1:0] e_sd;
    int                         e_now;
    int                         e_drop;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  logic [EVENT_BITS-1:0]      mq[$];
  bit                         m_sync, m_send, m_live;
  logic [RAVENS_PKT_BITS-1:0] m_spk;
  int                         m_now, m_pre, m_drop;

  int  found, seen_now, k, rts, n0, spk_seen;
  bit  acc;
  int  got[$];
  int  when[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [EVENT_BITS-1:0] mk_evt(input int x, input int y, input bit pol, input int ts);
    return {DVS_X_ADDR_BITS'(x), DVS_Y_ADDR_BITS'(y), pol, DVS_TS_BITS'(ts)};
  endfunction

  // Spec mapping: idx = (x + y*width) mod 256, placed at bit 5.
  function automatic logic [RAVENS_PKT_BITS-1:0] pkt_of(input int x, input int y);
    int idx;
    idx = (x + y * DVS_WIDTH_PXLS) % 256;
    return RAVENS_PKT_BITS'(idx * 32);
  endfunction

  function automatic logic [RAVENS_PKT_BITS-1:0] pkt_of_evt(input logic [EVENT_BITS-1:0] ev);
    return pkt_of(int'(ev[EVENT_BITS-1 -: DVS_X_ADDR_BITS]),
                  int'(ev[EVENT_BITS-1-DVS_X_ADDR_BITS -: DVS_Y_ADDR_BITS]));
  endfunction

  function automatic int ts_of(input logic [EVENT_BITS-1:0] ev);
    return int'(ev[DVS_TS_BITS-1:0]);
  endfunction

  function automatic vec_t mkv(input logic en, input logic ev_v, input logic [EVENT_BITS-1:0] ev,
                               input logic sr, input logic e_rdy, input logic e_sv,
                               input logic [RAVENS_PKT_BITS-1:0] e_sd, input int e_now, input int e_drop);
    vec_t v;
    v.en = en; v.ev_v = ev_v; v.ev = ev; v.sr = sr;
    v.e_rdy = e_rdy; v.e_sv = e_sv; v.e_sd = e_sd; v.e_now = e_now; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.evt_valid = 1'b0;
    bus.spk_ready = 1'b0;
    flush  = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // One clock of the spec's behaviour, on a queue and integer clock.
  task automatic model_step(input bit fl, input bit en, input bit sr,
                            input logic [EVENT_BITS-1:0] ev, input bit push);
    int d;
    if (fl) begin
      mq.delete();
      m_send = 0; m_drop = 0; m_sync = 0; m_pre = 0;
      return;
    end
    if (!m_sync) begin
      if (mq.size() > 0) begin
        m_now = ts_of(mq[0]); m_pre = 0; m_sync = 1;
      end
    end else begin
      if (!m_send) begin
        if (mq.size() > 0) begin
          d = (m_now - ts_of(mq[0]) + TSM) % TSM;
          if (d < TSM/2 && d > MAXLAG) begin
            void'(mq.pop_front());
            if (m_drop < 65535) m_drop++;
          end else if (d < TSM/2 && en) begin
            m_spk = pkt_of_evt(mq[0]);
            void'(mq.pop_front());
            m_send = 1;
          end
        end
      end else if (sr) begin
        m_send = 0;
      end
      m_pre++;
      if (m_pre == TICK) begin
        m_pre = 0;
        m_now = (m_now + 1) % TSM;
      end
    end
    if (push) mq.push_back(ev);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.evt_valid = 1'b0;
    bus.evt_data  = '0;
    bus.spk_ready = 1'b0;

    // ---- reset state ----
    #12;
    chk("rst_evt_ready", 64'(bus.evt_ready), 64'(0));
    chk("rst_spk_valid", 64'(bus.spk_valid), 64'(0));
    chk("rst_spk_data",  64'(bus.spk_data),  64'(0));
    chk("rst_now_us",    64'(now_us),        64'(0));
    chk("rst_drop_cnt",  64'(drop_cnt),      64'(0));
    rst_n = 1'b1;

    // ---- scenario 1 as a vector table ----
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 0, '0,             0,   0));
    tbl.push_back(mkv(1, 1, mk_evt(3, 0, 1, 100), 1, 1, 0, '0,             0,   0));
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 0, '0,             100, 0));
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 1, 32'h60,         100, 0));
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 0, '0,             100, 0));
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 0, '0,             100, 0));
    tbl.push_back(mkv(1, 0, '0,                   1, 1, 0, '0,             101, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      enable        = tbl[i].en;
      bus.evt_valid = tbl[i].ev_v;
      bus.evt_data  = tbl[i].ev;
      bus.spk_ready = tbl[i].sr;
      tick();
      chk($sformatf("v%0d_evt_ready", i), 64'(bus.evt_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_spk_valid", i), 64'(bus.spk_valid), 64'(tbl[i].e_sv));
      if (tbl[i].e_sv) chk($sformatf("v%0d_spk_data", i), 64'(bus.spk_data), 64'(tbl[i].e_sd));
      chk($sformatf("v%0d_now_us", i),    64'(now_us),        64'(tbl[i].e_now));
      chk($sformatf("v%0d_drop_cnt", i),  64'(drop_cnt),      64'(tbl[i].e_drop));
    end

    // ---- scenario 2: second spike waits for its timestamp ----
    do_reset();
    bus.spk_ready = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(1, 0, 0, 100);
    tick();
    bus.evt_data  = mk_evt(2, 0, 0, 103);
    tick();
    bus.evt_valid = 1'b0;
    found = 0; seen_now = -1;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.spk_valid && bus.spk_data == pkt_of(2, 0)) begin
        found = 1; seen_now = int'(now_us);
      end
    end
    chk("s2_found",    64'(found),    64'(1));
    chk("s2_now_at_2", 64'(seen_now), 64'(103));

    // ---- scenario 3: stale event dropped while enable is low ----
    do_reset();
    bus.spk_ready = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(5, 1, 0, 100);
    tick();
    bus.evt_valid = 1'b0;
    repeat (3) tick();
    enable = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (now_us == 16'd115) found = 1;
    end
    chk("s3_reach_115", 64'(found), 64'(1));
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(6, 0, 0, 101);
    tick();
    bus.evt_valid = 1'b0;
    spk_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.spk_valid) spk_seen = 1;
    end
    chk("s3_drop_cnt", 64'(drop_cnt), 64'(1));
    chk("s3_no_spike", 64'(spk_seen), 64'(0));

    // ---- scenario 4: release across timestamp wrap ----
    do_reset();
    bus.spk_ready = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(1, 0, 0, TSM - 2);
    tick();
    bus.evt_valid = 1'b0;
    repeat (3) tick();
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(7, 2, 1, 1);
    tick();
    bus.evt_valid = 1'b0;
    found = 0; seen_now = -1;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.spk_valid) begin
        found = 1; seen_now = int'(now_us);
        chk("s4_spk_data", 64'(bus.spk_data), 64'(pkt_of(7, 2)));
      end
    end
    chk("s4_found",    64'(found),    64'(1));
    chk("s4_now",      64'(seen_now), 64'(1));
    chk("s4_drop_cnt", 64'(drop_cnt), 64'(0));

    // ---- scenario 5: backpressure fills the FIFO, then drains in order ----
    do_reset();
    bus.spk_ready = 1'b0;
    k = 0;
    bus.evt_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.evt_data = mk_evt(k, 1, 1, 50);
      acc = bus.evt_ready;
      tick();
      if (acc) k++;
    end
    bus.evt_valid = 1'b0;
    chk("s5_accepted",  64'(k),             64'(DEPTH + 1));
    chk("s5_evt_ready", 64'(bus.evt_ready), 64'(0));
    chk("s5_held_vld",  64'(bus.spk_valid), 64'(1));
    chk("s5_held_data", 64'(bus.spk_data),  64'(pkt_of(0, 1)));
    got.delete(); when.delete();
    bus.spk_ready = 1'b1;
    if (bus.spk_valid) begin got.push_back(int'(bus.spk_data)); when.push_back(-1); end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.spk_valid) begin got.push_back(int'(bus.spk_data)); when.push_back(c); end
    end
    chk("s5_count", 64'(got.size()), 64'(DEPTH + 1));
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("s5_order%0d", i), 64'(got[i]), 64'(pkt_of(i, 1)));
      if (i > 0) chk($sformatf("s5_gap%0d", i), 64'(when[i] - when[i-1]), 64'(2));
    end

    // ---- scenario 6: flush with a spike presented and FIFO half full ----
    do_reset();
    bus.spk_ready = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(1, 0, 0, 200);
    tick();
    bus.evt_valid = 1'b0;
    repeat (3) tick();
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(2, 0, 0, 150);
    tick();
    bus.evt_valid = 1'b0;
    repeat (2) tick();
    chk("s6_pre_drop", 64'(drop_cnt), 64'(1));
    bus.spk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.evt_valid = 1'b1;
      bus.evt_data  = mk_evt(10 + i, 0, 0, int'(now_us));
      tick();
    end
    bus.evt_valid = 1'b0;
    tick();
    chk("s6_pre_vld",  64'(bus.spk_valid), 64'(1));
    chk("s6_pre_data", 64'(bus.spk_data),  64'(pkt_of(10, 0)));
    n0 = int'(now_us);
    flush = 1'b1;
    #1;
    chk("s6_rdy_in_flush", 64'(bus.evt_ready), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("s6_vld",  64'(bus.spk_valid), 64'(0));
    chk("s6_drop", 64'(drop_cnt),      64'(0));
    chk("s6_now",  64'(now_us),        64'(n0));
    chk("s6_rdy",  64'(bus.evt_ready), 64'(1));
    spk_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.spk_valid) spk_seen = 1;
    end
    chk("s6_empty_no_spk", 64'(spk_seen), 64'(0));
    chk("s6_now_frozen",   64'(now_us),   64'(n0));
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(20, 0, 0, 16'h1234);
    tick();
    bus.evt_valid = 1'b0;
    tick();
    chk("s6_resync", 64'(now_us), 64'(16'h1234));
    tick();
    chk("s6_new_vld",  64'(bus.spk_valid), 64'(1));
    chk("s6_new_data", 64'(bus.spk_data),  64'(pkt_of(20, 0)));

    // ---- reset mid-operation ----
    bus.evt_valid = 1'b1;
    bus.evt_data  = mk_evt(30, 0, 0, 16'h1234);
    tick();
    bus.evt_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_vld",  64'(bus.spk_valid), 64'(0));
    chk("mr_now",  64'(now_us),        64'(0));
    chk("mr_drop", 64'(drop_cnt),      64'(0));
    chk("mr_rdy",  64'(bus.evt_ready), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mr_fifo_lost", 64'(now_us),        64'(0));
    chk("mr_idle_vld",  64'(bus.spk_valid), 64'(0));

    // ---- randomized run against the reference model ----
    do_reset();
    mq.delete();
    m_sync = 0; m_send = 0; m_live = 1; m_spk = '0;
    m_now = 0; m_pre = 0; m_drop = 0;
    for (int c = 0; c < 2500; c++) begin
      flush         = ($urandom_range(0, 59) == 0);
      enable        = ($urandom_range(0, 9) < 8);
      bus.spk_ready = ($urandom_range(0, 9) < 6);
      bus.evt_valid = ($urandom_range(0, 1) == 1);
      if (m_sync) rts = (m_now + TSM + int'($urandom_range(0, 20)) - 14) % TSM;
      else        rts = int'($urandom_range(0, TSM - 1));
      bus.evt_data = mk_evt(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                            $urandom_range(0, 1) == 1, rts);
      acc = bus.evt_valid && m_live && (mq.size() < DEPTH) && !flush;
      tick();
      model_step(flush, enable, bus.spk_ready, bus.evt_data, acc);
      chk($sformatf("rnd%0d_evt_ready", c), 64'(bus.evt_ready),
          64'(m_live && (mq.size() < DEPTH) && !flush));
      chk($sformatf("rnd%0d_spk_valid", c), 64'(bus.spk_valid), 64'(m_send));
      if (m_send) chk($sformatf("rnd%0d_spk_data", c), 64'(bus.spk_data), 64'(m_spk));
      chk($sformatf("rnd%0d_now_us", c),   64'(now_us),   64'(m_now));
      chk($sformatf("rnd%0d_drop_cnt", c), 64'(drop_cnt), 64'(m_drop));
    end
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dvs_spike_scheduler.md
Name: dvs_spike_scheduler

Overview:
Timestamp-paced scheduler between the DVS event stream and the RAVENS input-spike port. It buffers incoming DVS events in a small FIFO and keeps a local microsecond timebase aligned to the camera timestamps. It releases each event as a RAVENS input spike packet only once its timestamp is due, and drops events that have fallen too far behind. It instantiates the event-to-spike converter on the FIFO head and owns the valid/ready sequencing on both sides.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
TICK_CYCLES, 100, clk cycles per microsecond tick; minimum 1.
MAX_LAG_US, 1000, head events with lag (now_us - ts) greater than this are dropped; must be less than 2^(DVS_TS_BITS-1).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  1 = spike release allowed; 0 = hold. Timebase and FIFO intake continue.
flush  in  1  synchronous clear of FIFO, output register, drop counter and sync.
evt_valid  in  1  DVS event valid.
evt_ready  out  1  event accept = evt_valid & evt_ready.
evt_data  in  EVENT_BITS  {x_addr, y_addr, polarity, ts_us}, MSB first.
spk_valid  out  1  spike packet valid.
spk_ready  in  1  downstream accept.
spk_data  out  RAVENS_PKT_BITS  RAVENS input spike packet (header 0, time 0, core/neuron from pixel index, port 0).
now_us  out  DVS_TS_BITS  current local timebase.
drop_cnt  out  16  stale events dropped; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - evt_ready=0 during reset, then 1 (FIFO empty).
  - spk_valid=0, spk_data=0, now_us=0, drop_cnt=0.
  - prescaler=0, FIFO empty, state=UNSYNC.
- FIFO:
  - evt_ready = !full & !flush.
  - A push is refused while full even if a pop occurs in the same cycle.
  - Pop happens only from the state machine.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 in WAIT and SEND.
  - now_us increments modulo 2^DVS_TS_BITS when the prescaler reaches TICK_CYCLES-1.
  - Both are frozen in UNSYNC.
- Timing arithmetic:
  - lag = now_us - head_ts, modulo 2^DVS_TS_BITS, interpreted as signed.
  - due = (lag >= 0).
  - stale = (lag > MAX_LAG_US).
  - Timestamp wrap is handled by the modular subtraction; no special case.
- State UNSYNC:
  - If the FIFO is non-empty: now_us <= head_ts, prescaler <= 0, go to WAIT.
  - The head is not popped.
- State WAIT (priority order):
  1. FIFO empty: stay.
  2. stale: pop, drop_cnt++ (saturating). Drops occur regardless of enable.
  3. due & enable: pop, register converter output into spk_data, spk_valid <= 1, go to SEND.
  4. Otherwise: stay.
- State SEND:
  - spk_valid and spk_data stay stable until spk_valid & spk_ready.
  - On handshake: spk_valid <= 0, go to WAIT.
  - Throughput is at most one spike per 2 clk cycles.
  - Deasserting enable in SEND does not withdraw a presented spike.
- Latency: an event accepted at edge N into an empty FIFO in UNSYNC gives spk_valid=1 after edge N+2 (sync at N+1, release at N+2).
- Spike packet mapping:
  - idx = (x + y*DVS_WIDTH_PXLS) mod 256.
  - spk_data = {3'b0, 16'b0, idx[7:4], idx[3:0], 5'b0}.
  - Polarity is ignored.
- flush:
  - Overrides everything in the cycle it is sampled.
  - Effects: FIFO empty, spk_valid=0, drop_cnt=0, state=UNSYNC, prescaler=0; now_us is held.
  - Any in-flight spike is discarded without handshake.
- Reset mid-operation: immediate return to the reset values; FIFO contents are lost.

Decomposition:
- dvs_ravens_pkg gains the following; other constants (EVENT_BITS, DVS_X_ADDR_BITS, DVS_Y_ADDR_BITS, DVS_WIDTH_PXLS, RAVENS_PKT_BITS) are reused as-is:
  - DVS_TS_BITS = EVENT_BITS - DVS_X_ADDR_BITS - DVS_Y_ADDR_BITS - 1.
  - typedef enum logic [1:0] {SCHED_UNSYNC, SCHED_WAIT, SCHED_SEND} sched_state_t.
- Sub-modules:
  - Existing dvs_event_to_ravens_spike, instantiated on the FIFO head.
  - One new sub-module, dvs_event_fifo: parameterised synchronous FIFO, first-word-fall-through, with full/empty outputs.
- Prescaler, timebase and FSM stay in the top module.

Test Plan:
All scenarios run with TICK_CYCLES=4, MAX_LAG_US=10.
1. Reset, then push x=3,y=0,ts=100 -> now_us=100 after 1 cycle; spk_valid=1 two cycles after accept; spk_data=0x60 (idx 3); with spk_ready=1 held, spk_valid drops the following cycle.
2. Push ts=100, then ts=103 -> second spike appears once now_us=103 (12 clk after sync), not earlier.
3. Sync at ts=100; hold enable=0 for 60 clk (now_us=115); push ts=101 -> dropped; drop_cnt=1; no spike.
4. Sync with ts=0xFFFF..FE (max-1), push ts=1 -> released 3 ticks later across the wrap; not dropped.
5. Hold spk_ready=0 and push FIFO_DEPTH+2 events with equal ts -> one spike held stable; evt_ready=0 once full; release spk_ready -> all FIFO_DEPTH+1 accepted events emerge in order, one per 2 clk.
6. Assert flush while spk_valid=1 with the FIFO half full -> next cycle spk_valid=0, FIFO empty, drop_cnt=0, state UNSYNC; the next push re-syncs now_us to its ts.
